cache_fill_ctrl: RTL and testbench

Parametrised, two-channel cache miss fill controller. Accepts block misses from the instruction cache and the data cache, arbitrates between them, and issues a pipelined burst of word reads to main memory. It steers returning words into the selected cache's data array, then writes the tag/valid entry. It sits between both caches' tag-match logic and the single memory read port, and supplies the per-cache pipeline stall signals.

---
 rtl/cache_fill_ctrl_pkg.sv | 24 ++
 rtl/cache_fill_ctrl_counter.sv | 37 +++
 rtl/cache_fill_ctrl.sv | 121 ++++++++++++
 tb/tb_cache_fill_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache miss fill controller: FSM states, channel
// encodings and width helpers derived from the block geometry.
package cache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        TAGWR = 2'd2
    } fill_state_e;

    localparam logic CH_I = 1'b0;
    localparam logic CH_D = 1'b1;

    // Byte-offset width of one block: log2(BLOCK_WORDS*WORD_BYTES).
    function automatic int offset_width(input int block_words, input int word_bytes);
        return $clog2(block_words * word_bytes);
    endfunction

    // Word counters must reach BLOCK_WORDS itself, hence the extra bit.
    function automatic int cnt_width(input int block_words);
        return $clog2(block_words) + 1;
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_counter.sv
// Word counter used for both the issue and the return side of a block fill:
// synchronous clear has priority over the count enable.
module fill_word_counter
    import cache_fill_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Two-channel (I/D) cache miss fill controller: arbitrates misses, issues a
// burst of word reads, steers returned words into the chosen cache, writes the tag.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WORD_BYTES  = 2,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           miss_i,
    input  logic [ADDR_W-1:0]              miss_addr_i,
    input  logic                           miss_d,
    input  logic [ADDR_W-1:0]              miss_addr_d,
    input  logic                           mem_data_valid,
    input  logic [DATA_W-1:0]              mem_data,
    output logic                           busy_i,
    output logic                           busy_d,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic                           fill_sel,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_offset,
    output logic                           data_we,
    output logic                           tag_we,
    output logic [ADDR_W-1:0]              fill_addr
);

    localparam int                CNT_W    = cnt_width(BLOCK_WORDS);
    localparam int                IDX_W    = CNT_W - 1;
    localparam int                BYTE_SH  = $clog2(WORD_BYTES);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << offset_width(BLOCK_WORDS, WORD_BYTES)) - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_WORDS - 1);

    fill_state_e       state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              accept;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  ret_cnt;
    logic [ADDR_W-1:0] word_off;

    fill_word_counter #(.CNT_W(CNT_W)) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (mem_rd),
        .cnt_o (issue_cnt)
    );

    fill_word_counter #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (accept),
        .en_i  (data_we),
        .cnt_o (ret_cnt)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        base_d  = base_q;
        accept  = 1'b0;
        mem_rd  = 1'b0;
        data_we = 1'b0;
        tag_we  = 1'b0;
        case (state_q)
            IDLE: begin
                // D has priority; a losing I miss simply stays asserted.
                if (miss_d || miss_i) begin
                    accept  = 1'b1;
                    sel_d   = miss_d ? CH_D : CH_I;
                    base_d  = (miss_d ? miss_addr_d : miss_addr_i) & ~BLK_MASK;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_rd  = (issue_cnt < CNT_FULL);
                data_we = mem_data_valid;
                if (mem_data_valid && (ret_cnt == CNT_LAST)) begin
                    state_d = TAGWR;
                end
            end
            TAGWR: begin
                tag_we  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= CH_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            base_q  <= base_d;
        end
    end

    // Word offset is ORed into the cleared low bits, so the sum never carries out of the block.
    assign word_off    = ADDR_W'(issue_cnt[IDX_W-1:0]) << BYTE_SH;
    assign mem_addr    = mem_rd ? (base_q | word_off) : '0;
    assign fill_offset = ret_cnt[IDX_W-1:0];
    assign fill_data   = mem_data;
    assign fill_sel    = sel_q;
    assign fill_addr   = base_q;

    // A channel stalls while its miss is outstanding or while its block is in flight.
    assign busy_i = miss_i | ((state_q != IDLE) & (sel_q == CH_I));
    assign busy_d = miss_d | ((state_q != IDLE) & (sel_q == CH_D));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized scoreboard bench for cache_fill_ctrl: two configurations (8x16-bit
// and 4x32-bit blocks) exercised in turn, checked by a monitor against queued expectations.
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg;
    logic        miss_i, miss_d;
    logic [15:0] addr_i, addr_d;
    logic        mvalid;
    logic [31:0] mdata;

    // Configuration 0 outputs
    logic        b0i, b0d, rd0, fs0, we0, tw0;
    logic [15:0] ma0, fa0, fd0;
    logic [2:0]  fo0;
    // Configuration 1 outputs
    logic        b1i, b1d, rd1, fs1, we1, tw1;
    logic [15:0] ma1, fa1;
    logic [31:0] fd1;
    logic [1:0]  fo1;

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8)) dut0 (
        .clk(clk), .rst(rst),
        .miss_i(miss_i & ~cfg), .miss_addr_i(addr_i),
        .miss_d(miss_d & ~cfg), .miss_addr_d(addr_d),
        .mem_data_valid(mvalid & ~cfg), .mem_data(mdata[15:0]),
        .busy_i(b0i), .busy_d(b0d), .mem_rd(rd0), .mem_addr(ma0),
        .fill_sel(fs0), .fill_data(fd0), .fill_offset(fo0),
        .data_we(we0), .tag_we(tw0), .fill_addr(fa0)
    );

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORD_BYTES(4), .BLOCK_WORDS(4)) dut1 (
        .clk(clk), .rst(rst),
        .miss_i(miss_i & cfg), .miss_addr_i(addr_i),
        .miss_d(miss_d & cfg), .miss_addr_d(addr_d),
        .mem_data_valid(mvalid & cfg), .mem_data(mdata),
        .busy_i(b1i), .busy_d(b1d), .mem_rd(rd1), .mem_addr(ma1),
        .fill_sel(fs1), .fill_data(fd1), .fill_offset(fo1),
        .data_we(we1), .tag_we(tw1), .fill_addr(fa1)
    );

    // View of the configuration currently under test
    logic        v_bi, v_bd, v_rd, v_fs, v_we, v_tw;
    logic [15:0] v_ma, v_fa;
    logic [31:0] v_fd;
    logic [2:0]  v_fo;

    always_comb begin
        if (cfg) begin
            v_bi = b1i; v_bd = b1d; v_rd = rd1; v_fs = fs1; v_we = we1; v_tw = tw1;
            v_ma = ma1; v_fa = fa1; v_fd = fd1; v_fo = {1'b0, fo1};
        end else begin
            v_bi = b0i; v_bd = b0d; v_rd = rd0; v_fs = fs0; v_we = we0; v_tw = tw0;
            v_ma = ma0; v_fa = fa0; v_fd = {16'h0000, fd0}; v_fo = fo0;
        end
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A3C, ~a};
    endfunction

    typedef struct packed {
        logic        sel;
        logic [2:0]  off;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        sel;
        logic [15:0] addr;
    } tag_t;

    logic [15:0] exp_rd_q[$];
    wr_t         exp_wr_q[$];
    tag_t        exp_tag_q[$];

    int tests = 0;
    int fails = 0;
    int to_req = 0;
    int to_seen = 0;
    bit fin_req = 1'b0;
    bit fin_done = 1'b0;

    // Memory model knobs, written by stimulus
    int lat_lo = 1;
    int lat_hi = 1;
    int gap_hi = 0;
    int stray_req = 0;
    int stray_done = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cfg %0d, t=%0t)", nm, got, want, cfg, $time);
        end
    endfunction

    // Memory: returns words in request order, latency >= 1, optional gaps
    logic [15:0] rsp_addr_q[$];
    int          rsp_due_q[$];
    int          rcyc = 0;
    int          last_due = 0;

    initial begin : memory
        int due, g;
        mvalid = 1'b0;
        mdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_addr_q.delete();
                rsp_due_q.delete();
                last_due = 0;
            end else if (v_rd) begin
                due = rcyc + int'($urandom_range(lat_hi, lat_lo));
                g   = int'($urandom_range(gap_hi, 0));
                if (due < last_due + 1 + g) due = last_due + 1 + g;
                last_due = due;
                rsp_addr_q.push_back(v_ma);
                rsp_due_q.push_back(due);
            end
            @(posedge clk);
            #1;
            rcyc++;
            if (!rst && rsp_due_q.size() > 0 && rsp_due_q[0] <= rcyc) begin
                mvalid = 1'b1;
                mdata  = mem_word(rsp_addr_q.pop_front());
                void'(rsp_due_q.pop_front());
            end else if (!rst && stray_done != stray_req) begin
                mvalid     = 1'b1;
                mdata      = $urandom;
                stray_done = stray_req;
            end else begin
                mvalid = 1'b0;
                mdata  = '0;
            end
        end
    end

    // Monitor: the reference model tracks which channel owns the fill, how many
    // reads and returns have happened, and whether this is the tag-write cycle.
    int own = -1;
    int rd_n = 0;
    int ret_n = 0;
    bit tag_now = 1'b0;

    always @(negedge clk) begin : monitor
        int   bwv;
        bit   exp_rd, exp_we;
        logic [31:0] dmask;
        wr_t  w;
        tag_t tg;
        bwv   = cfg ? 4 : 8;
        dmask = cfg ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        if (to_req != to_seen) begin
            chk("wait_timeout", 64'(to_req), 64'(to_seen));
            to_seen = to_req;
        end
        if (rst) begin
            chk("rst_outputs", 64'({v_rd, v_we, v_tw, v_fs, v_ma, v_fa, v_fo}), 64'(0));
            chk("rst_busy_i", 64'(v_bi), 64'(miss_i));
            chk("rst_busy_d", 64'(v_bd), 64'(miss_d));
            own = -1; rd_n = 0; ret_n = 0; tag_now = 1'b0;
            exp_rd_q.delete();
            exp_wr_q.delete();
            exp_tag_q.delete();
        end else begin
            chk("busy_i", 64'(v_bi), 64'(miss_i || own == 0));
            chk("busy_d", 64'(v_bd), 64'(miss_d || own == 1));
            exp_rd = (own >= 0) && !tag_now && (rd_n < bwv);
            exp_we = (own >= 0) && !tag_now && mvalid;
            chk("mem_rd", 64'(v_rd), 64'(exp_rd));
            if (exp_rd && exp_rd_q.size() > 0)
                chk("mem_addr", 64'(v_ma), 64'(exp_rd_q.pop_front()));
            chk("data_we", 64'(v_we), 64'(exp_we));
            if (exp_we && exp_wr_q.size() > 0) begin
                w = exp_wr_q.pop_front();
                chk("fill_sel_wr", 64'(v_fs), 64'(w.sel));
                chk("fill_offset", 64'(v_fo), 64'(w.off));
                chk("fill_data", 64'(v_fd), 64'(w.data & dmask));
            end
            chk("tag_we", 64'(v_tw), 64'(tag_now));
            if (tag_now && exp_tag_q.size() > 0) begin
                tg = exp_tag_q.pop_front();
                chk("fill_sel_tag", 64'(v_fs), 64'(tg.sel));
                chk("fill_addr", 64'(v_fa), 64'(tg.addr));
            end
            if (tag_now) begin
                own = -1;
                tag_now = 1'b0;
            end else if (own >= 0) begin
                if (exp_rd) rd_n++;
                if (exp_we) begin
                    ret_n++;
                    if (ret_n == bwv) tag_now = 1'b1;
                end
            end else if (miss_d || miss_i) begin
                own = miss_d ? 1 : 0;
                rd_n = 0;
                ret_n = 0;
            end
        end
        if (fin_req && !fin_done) begin
            chk("leftover_reads", 64'(exp_rd_q.size()), 64'(0));
            chk("leftover_writes", 64'(exp_wr_q.size()), 64'(0));
            chk("leftover_tags", 64'(exp_tag_q.size()), 64'(0));
            fin_done = 1'b1;
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_fill(input bit ch, input logic [15:0] a);
        int          bwv, wbv;
        logic [15:0] base, wa;
        wr_t         w;
        tag_t        tg;
        bwv  = cfg ? 4 : 8;
        wbv  = cfg ? 4 : 2;
        base = a & ~16'(bwv * wbv - 1);
        for (int k = 0; k < bwv; k++) begin
            wa = base + 16'(k * wbv);
            exp_rd_q.push_back(wa);
            w.sel  = ch;
            w.off  = 3'(k);
            w.data = mem_word(wa);
            exp_wr_q.push_back(w);
        end
        tg.sel  = ch;
        tg.addr = base;
        exp_tag_q.push_back(tg);
    endtask

    task automatic raise_miss(input bit ch, input logic [15:0] a);
        if (ch) begin
            miss_d = 1'b1;
            addr_d = a;
        end else begin
            miss_i = 1'b1;
            addr_i = a;
        end
    endtask

    task automatic wait_tag(input bit ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            tick();
            if (v_tw && v_fs == ch) seen = 1'b1;
        end
        if (!seen) to_req++;
    endtask

    task automatic do_fill(input bit ch, input logic [15:0] a, input int lo, input int hi, input int gap);
        lat_lo = lo;
        lat_hi = hi;
        gap_hi = gap;
        push_fill(ch, a);
        raise_miss(ch, a);
        wait_tag(ch);
        if (ch) miss_d = 1'b0; else miss_i = 1'b0;
        tick();
    endtask

    task automatic run_cfg();
        int cnt;
        // Single D miss, fixed latency 3
        do_fill(1'b1, 16'h1236, 3, 3, 0);
        tick();
        // Simultaneous misses: D first, then the held I miss
        lat_lo = 1; lat_hi = 3; gap_hi = 0;
        push_fill(1'b1, 16'h0200);
        push_fill(1'b0, 16'h0100);
        raise_miss(1'b1, 16'h0200);
        raise_miss(1'b0, 16'h0100);
        wait_tag(1'b1);
        miss_d = 1'b0;
        wait_tag(1'b0);
        miss_i = 1'b0;
        tick();
        // Top-of-memory block
        do_fill(1'b0, 16'hFFFF, 1, 2, 0);
        do_fill(1'b1, 16'hFFF1, 2, 2, 0);
        // Random fills with gapped returns
        for (int n = 0; n < 6; n++) begin
            do_fill(1'($urandom), 16'($urandom), 1, 4, 4);
            repeat ($urandom_range(2, 0)) tick();
        end
        // Stray valid in IDLE, then a normal fill
        stray_req++;
        repeat (3) tick();
        do_fill(1'b0, 16'h4A5B, 1, 1, 2);
        // Reset after three returned words, then a complete fill
        lat_lo = 1; lat_hi = 2; gap_hi = 1;
        push_fill(1'b1, 16'h7766);
        raise_miss(1'b1, 16'h7766);
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 3; i++) begin
            tick();
            if (v_we) cnt++;
        end
        if (cnt < 3) to_req++;
        rst    = 1'b1;
        miss_d = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_fill(1'b1, 16'h9ABC, 1, 3, 1);
        do_fill(1'b0, 16'h0011, 1, 1, 0);
    endtask

    initial begin : stimulus
        rst    = 1'b1;
        cfg    = 1'b0;
        miss_i = 1'b0;
        miss_d = 1'b0;
        addr_i = '0;
        addr_d = '0;
        for (int c = 0; c < 2; c++) begin
            rst = 1'b1;
            cfg = c[0];
            repeat (3) tick();
            rst = 1'b0;
            repeat (2) tick();
            run_cfg();
        end
        fin_req = 1'b1;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
